// File: rtl/sprint1_ctrl_pkg.sv
// Shared types and constants for the Sprint 1 input sequencer:
// gear encoding, quadrature phase helpers and steering FSM states.
package sprint1_ctrl_pkg;

    typedef logic [1:0] gear_t;
    typedef logic [1:0] quad_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CW   = 2'd1,
        CCW  = 2'd2
    } steer_st_t;

    localparam gear_t GEAR_MAX = 2'd3;
    localparam gear_t GEAR_MIN = 2'd0;

    // Active-low {gear3_n, gear2_n, gear1_n}; top gear closes no switch.
    localparam logic [2:0] GEAR_N_LUT [4] = '{3'b110, 3'b101, 3'b011, 3'b111};

    // One Gray step: CW walks 00->01->11->10->00, CCW walks it backwards.
    function automatic quad_t quad_next(input quad_t q, input logic cw);
        quad_t r;
        case (q)
            2'b00:   r = cw ? 2'b01 : 2'b10;
            2'b01:   r = cw ? 2'b11 : 2'b00;
            2'b11:   r = cw ? 2'b10 : 2'b01;
            default: r = cw ? 2'b00 : 2'b11;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sprint1_ctrl_seq_debounce.sv
// Two-flop synchronizer followed by a stability counter. The debounced
// level only follows the synchronized input after it has differed from
// it for DEBOUNCE_CYC consecutive cycles.
module sprint1_debounce #(
    parameter int DEBOUNCE_CYC = 4096
) (
    input  logic clk_12,
    input  logic rst_n,
    input  logic din,
    output logic level_o
);
    localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             synced;

    assign synced  = sync_q[1];
    assign level_o = level_q;

    // Count while the synced input disagrees with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (synced != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, counter and accepted level registers.
    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], din};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/sprint1_ctrl_seq.sv
// Sprint 1 input sequencer: debounced gear shifter and rate-divided
// quadrature steering generator.
// Optional build macro SPRINT1_STEER_ACCEL_EN: doubles the steering step
// rate after ACCEL_STEPS consecutive same-direction steps.
//
// state | meaning
// IDLE  | no single direction held; prescaler at 0, phase frozen
// CW    | right held; phase walks 00->01->11->10
// CCW   | left held; phase walks 00->10->11->01
module sprint1_ctrl_seq
    import sprint1_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4096,
    parameter int STEER_DIV    = 12096
`ifdef SPRINT1_STEER_ACCEL_EN
    ,
    parameter int ACCEL_STEPS  = 8
`endif
) (
    input  logic       clk_12,
    input  logic       Reset_n,
    input  logic       left,
    input  logic       right,
    input  logic       gear_up,
    input  logic       gear_down,
    output logic [2:0] gear_n,
    output logic       steer_a,
    output logic       steer_b,
    output logic [1:0] gear_num,
    output logic       step_strb
);
    localparam int PW = $clog2(STEER_DIV);
    localparam logic [PW-1:0] WRAP_BASE = PW'(STEER_DIV - 1);

    logic      up_lvl, dn_lvl, up_prev_q, dn_prev_q, up_rise, dn_rise;
    gear_t     gear_q, gear_d;
    logic [2:0] gear_n_q, gear_n_d;

    logic [1:0]    lsync_q, rsync_q;
    steer_st_t     st_q, st_d;
    logic [PW-1:0] presc_q, presc_d, cnt_cur, wrap_pt;
    quad_t         phase_q, phase_d;
    logic          strb_q, strb_d, wrap;

`ifdef SPRINT1_STEER_ACCEL_EN
    localparam logic [PW-1:0] WRAP_FAST = PW'(STEER_DIV / 2 - 1);
    localparam logic [3:0]    ACCEL_TH  = 4'(ACCEL_STEPS);
    logic [3:0] run_q, run_d;
`endif

    sprint1_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_up (
        .clk_12 (clk_12),
        .rst_n  (Reset_n),
        .din    (gear_up),
        .level_o(up_lvl)
    );

    sprint1_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_dn (
        .clk_12 (clk_12),
        .rst_n  (Reset_n),
        .din    (gear_down),
        .level_o(dn_lvl)
    );

    assign up_rise = up_lvl & ~up_prev_q;
    assign dn_rise = dn_lvl & ~dn_prev_q;

    // Saturating gear step; simultaneous up and down edges cancel.
    always_comb begin
        gear_d = gear_q;
        if (up_rise && !dn_rise && gear_q != GEAR_MAX) begin
            gear_d = gear_q + 1'b1;
        end else if (dn_rise && !up_rise && gear_q != GEAR_MIN) begin
            gear_d = gear_q - 1'b1;
        end
        gear_n_d = GEAR_N_LUT[gear_d];
    end

    // Steering next state, prescaler and phase; a state change restarts the count.
    always_comb begin
        case ({rsync_q[1], lsync_q[1]})
            2'b10:   st_d = CW;
            2'b01:   st_d = CCW;
            default: st_d = IDLE;
        endcase
        cnt_cur = (st_d != st_q) ? '0 : presc_q;
        wrap_pt = WRAP_BASE;
`ifdef SPRINT1_STEER_ACCEL_EN
        if (run_q >= ACCEL_TH) begin
            wrap_pt = WRAP_FAST;
        end
`endif
        wrap    = (st_d != IDLE) && (cnt_cur == wrap_pt);
        presc_d = (st_d == IDLE || wrap) ? '0 : cnt_cur + 1'b1;
        phase_d = wrap ? quad_next(phase_q, st_d == CW) : phase_q;
        strb_d  = wrap;
`ifdef SPRINT1_STEER_ACCEL_EN
        run_d = (st_d != st_q || st_d == IDLE) ? 4'd0 : run_q;
        if (wrap && run_d != 4'hF) begin
            run_d = run_d + 1'b1;
        end
`endif
    end

    // All sequencer state; every output is taken straight from here.
    always_ff @(posedge clk_12 or negedge Reset_n) begin
        if (!Reset_n) begin
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
            gear_q    <= GEAR_MIN;
            gear_n_q  <= 3'b110;
            lsync_q   <= 2'b00;
            rsync_q   <= 2'b00;
            st_q      <= IDLE;
            presc_q   <= '0;
            phase_q   <= 2'b00;
            strb_q    <= 1'b0;
`ifdef SPRINT1_STEER_ACCEL_EN
            run_q     <= 4'd0;
`endif
        end else begin
            up_prev_q <= up_lvl;
            dn_prev_q <= dn_lvl;
            gear_q    <= gear_d;
            gear_n_q  <= gear_n_d;
            lsync_q   <= {lsync_q[0], left};
            rsync_q   <= {rsync_q[0], right};
            st_q      <= st_d;
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            strb_q    <= strb_d;
`ifdef SPRINT1_STEER_ACCEL_EN
            run_q     <= run_d;
`endif
        end
    end

    assign gear_num  = gear_q;
    assign gear_n    = gear_n_q;
    assign steer_a   = phase_q[1];
    assign steer_b   = phase_q[0];
    assign step_strb = strb_q;

endmodule

// File: tb/tb_sprint1_ctrl_seq.sv
// Directed bench for sprint1_ctrl_seq with DEBOUNCE_CYC=4, STEER_DIV=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_sprint1_ctrl_seq;

    logic       clk_12 = 1'b0;
    logic       Reset_n = 1'b0;
    logic       left = 1'b0, right = 1'b0, gear_up = 1'b0, gear_down = 1'b0;
    logic [2:0] gear_n;
    logic       steer_a, steer_b, step_strb;
    logic [1:0] gear_num;

    int errors = 0;
    int checks = 0;
    int strb_cnt = 0;
    int s0, s1;

    logic [1:0] exp_g [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [2:0] exp_n [4] = '{3'b101, 3'b011, 3'b111, 3'b111};
    logic [1:0] prev_g;

    sprint1_ctrl_seq #(
        .DEBOUNCE_CYC(4),
        .STEER_DIV(4)
`ifdef SPRINT1_STEER_ACCEL_EN
        ,
        .ACCEL_STEPS(8)
`endif
    ) dut (
        .clk_12   (clk_12),
        .Reset_n  (Reset_n),
        .left     (left),
        .right    (right),
        .gear_up  (gear_up),
        .gear_down(gear_down),
        .gear_n   (gear_n),
        .steer_a  (steer_a),
        .steer_b  (steer_b),
        .gear_num (gear_num),
        .step_strb(step_strb)
    );

    always #5 clk_12 = ~clk_12;

    always @(negedge clk_12) begin
        if (step_strb === 1'b1) strb_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_12);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values while held
        tick(3);
        chk("rst_gear_num", 8'(gear_num), 8'd0);
        chk("rst_gear_n", 8'(gear_n), 8'b110);
        chk("rst_phase", 8'({steer_a, steer_b}), 8'd0);
        chk("rst_strb", 8'(step_strb), 8'd0);
        Reset_n = 1'b1;
        tick(20);
        chk("idle_gear_num", 8'(gear_num), 8'd0);
        chk("idle_gear_n", 8'(gear_n), 8'b110);
        chk("idle_phase", 8'({steer_a, steer_b}), 8'd0);
        chk("idle_strb_cnt", 8'(strb_cnt), 8'd0);

        // Four held gear_up presses: 1,2,3,3 each 7 cycles after the input
        prev_g = 2'd0;
        for (int p = 0; p < 4; p++) begin
            gear_up = 1'b1;
            tick(6);
            chk("gear_up_latency", 8'(gear_num), 8'(prev_g));
            tick(1);
            chk("gear_up_num", 8'(gear_num), 8'(exp_g[p]));
            chk("gear_up_n", 8'(gear_n), 8'(exp_n[p]));
            prev_g = exp_g[p];
            tick(3);
            gear_up = 1'b0;
            tick(10);
        end

        // Short glitches are ignored; a 4-cycle pulse is accepted
        gear_up = 1'b1; tick(2); gear_up = 1'b0; tick(12);
        chk("glitch2_up", 8'(gear_num), 8'd3);
        gear_down = 1'b1; tick(3); gear_down = 1'b0; tick(12);
        chk("glitch3_dn", 8'(gear_num), 8'd3);
        gear_down = 1'b1; tick(4); gear_down = 1'b0; tick(3);
        chk("pulse4_dn_num", 8'(gear_num), 8'd2);
        chk("pulse4_dn_n", 8'(gear_n), 8'b011);
        tick(10);
        gear_down = 1'b1; tick(7);
        chk("gear_dn_num", 8'(gear_num), 8'd1);
        chk("gear_dn_n", 8'(gear_n), 8'b101);
        tick(3); gear_down = 1'b0; tick(10);

        // Simultaneous up and down cancel
        gear_up = 1'b1; gear_down = 1'b1; tick(7);
        chk("both_rise", 8'(gear_num), 8'd1);
        tick(3); gear_up = 1'b0; gear_down = 1'b0; tick(10);
        chk("both_release", 8'(gear_num), 8'd1);
        gear_up = 1'b1; tick(7);
        chk("to_gear3_num", 8'(gear_num), 8'd2);
        chk("to_gear3_n", 8'(gear_n), 8'b011);
        tick(3); gear_up = 1'b0; tick(10);

        // Right held 20 cycles: steps at 6,10,14,18,22
        s0 = strb_cnt;
        right = 1'b1; tick(5);
        chk("cw_pre_strb", 8'(step_strb), 8'd0);
        chk("cw_pre_phase", 8'({steer_a, steer_b}), 8'b00);
        tick(1);
        chk("cw1_strb", 8'(step_strb), 8'd1);
        chk("cw1_phase", 8'({steer_a, steer_b}), 8'b01);
        tick(1);
        chk("cw1_strb_end", 8'(step_strb), 8'd0);
        tick(3);
        chk("cw2_strb", 8'(step_strb), 8'd1);
        chk("cw2_phase", 8'({steer_a, steer_b}), 8'b11);
        tick(4);
        chk("cw3_phase", 8'({steer_a, steer_b}), 8'b10);
        tick(4);
        chk("cw4_phase", 8'({steer_a, steer_b}), 8'b00);
        chk("cw4_strb", 8'(step_strb), 8'd1);
        tick(2); right = 1'b0; tick(2);
        chk("cw5_phase", 8'({steer_a, steer_b}), 8'b01);
        chk("cw5_strb", 8'(step_strb), 8'd1);
        tick(5);
        chk("cw_strb_count", 8'(strb_cnt - s0), 8'd5);
        chk("cw_idle_phase", 8'({steer_a, steer_b}), 8'b01);

        // Direction change mid-count restarts the prescaler and reverses
        right = 1'b1; tick(6);
        chk("dir_cw_phase", 8'({steer_a, steer_b}), 8'b11);
        tick(1); right = 1'b0; left = 1'b1; tick(3);
        chk("dir_restart_strb", 8'(step_strb), 8'd0);
        chk("dir_restart_phase", 8'({steer_a, steer_b}), 8'b11);
        tick(3);
        chk("ccw1_strb", 8'(step_strb), 8'd1);
        chk("ccw1_phase", 8'({steer_a, steer_b}), 8'b01);
        tick(4);
        chk("ccw2_phase", 8'({steer_a, steer_b}), 8'b00);

        // Both held: frozen
        right = 1'b1; tick(1);
        s1 = strb_cnt;
        tick(15);
        chk("both_strb_count", 8'(strb_cnt - s1), 8'd0);
        chk("both_phase", 8'({steer_a, steer_b}), 8'b00);
        left = 1'b0; right = 1'b0; tick(5);

        // Async reset mid-step at gear 3
        right = 1'b1; tick(7);
        chk("pre_rst_gear", 8'(gear_num), 8'd2);
        chk("pre_rst_phase", 8'({steer_a, steer_b}), 8'b01);
        #2; Reset_n = 1'b0; #1;
        chk("async_rst_gear_num", 8'(gear_num), 8'd0);
        chk("async_rst_gear_n", 8'(gear_n), 8'b110);
        chk("async_rst_phase", 8'({steer_a, steer_b}), 8'b00);
        chk("async_rst_strb", 8'(step_strb), 8'd0);
        right = 1'b0; tick(2);
        Reset_n = 1'b1; tick(5);
        chk("post_rst_gear", 8'(gear_num), 8'd0);

`ifdef SPRINT1_STEER_ACCEL_EN
        // 8 steps 4 apart, then 2 apart; release restores base rate
        s0 = strb_cnt;
        right = 1'b1; tick(34);
        chk("acc8_strb", 8'(step_strb), 8'd1);
        chk("acc8_phase", 8'({steer_a, steer_b}), 8'b00);
        tick(1);
        chk("acc8_strb_end", 8'(step_strb), 8'd0);
        tick(1);
        chk("acc9_strb", 8'(step_strb), 8'd1);
        chk("acc9_phase", 8'({steer_a, steer_b}), 8'b01);
        tick(2);
        chk("acc10_strb", 8'(step_strb), 8'd1);
        right = 1'b0; tick(2);
        chk("acc11_phase", 8'({steer_a, steer_b}), 8'b10);
        tick(8);
        chk("acc_strb_count", 8'(strb_cnt - s0), 8'd11);
        right = 1'b1; tick(6);
        chk("acc_restart1", 8'(step_strb), 8'd1);
        tick(2);
        chk("acc_restart_gap", 8'(step_strb), 8'd0);
        tick(2);
        chk("acc_restart2", 8'(step_strb), 8'd1);
        right = 1'b0; tick(5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprint1_ctrl_seq.md
Name: sprint1_ctrl_seq

Overview:
- Input sequencer that sits between the arcade input decoder and the Sprint 1 core.
- Emulates the cabinet's 4-position gear shifter and optical steering wheel.
- Gear: debounced gear-up/gear-down buttons step a saturating gear register, which drives the core's active-low gear switch lines.
- Steering: held left/right digital inputs drive a rate-divided 2-bit quadrature generator, which feeds the core's steering inputs.

Parameters:
- DEBOUNCE_CYC, 4096: cycles a synchronized button level must stay stable before it is accepted (min 2).
- STEER_DIV, 12096: clk_12 cycles per quadrature step at base rate (min 4; 1 ms at 12.096 MHz).
- ACCEL_STEPS, 8: consecutive same-direction steps before acceleration (used only with SPRINT1_STEER_ACCEL_EN).

Ports:
- clk_12  in  1  system clock, 12.096 MHz
- Reset_n  in  1  asynchronous active-low reset
- left  in  1  steer left request, active high, asynchronous to clk_12
- right  in  1  steer right request, active high, asynchronous
- gear_up  in  1  shift-up button, active high, asynchronous
- gear_down  in  1  shift-down button, active high, asynchronous
- gear_n  out  3  active-low gear switches {gear3_n, gear2_n, gear1_n}
- steer_a  out  1  quadrature phase A
- steer_b  out  1  quadrature phase B
- gear_num  out  2  current gear minus 1 (0..3), for OSD/debug
- step_strb  out  1  one-cycle pulse on each quadrature step

Behaviour:
- Reset: all flops clear asynchronously when Reset_n=0.
  - gear_num=0 and gear_n=3'b110 (gear 1).
  - Quadrature phase=00, so steer_a=0, steer_b=0.
  - step_strb=0; prescaler, debounce counters and debounced levels=0.
  - Release is synchronous to clk_12 edges; no output glitches on release.
- Synchronizers: all four inputs pass through 2-flop synchronizers before any use.
- Debounce, per button:
  - Counter resets to 0 whenever the synced level equals the debounced level.
  - Otherwise it increments each cycle.
  - When it reaches DEBOUNCE_CYC-1 while the levels still differ, the debounced level takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles produces no change.
- Gear register:
  - Rising edge of debounced up: gear_num increments, saturating at 3.
  - Rising edge of debounced down: gear_num decrements, saturating at 0.
  - Both rising edges in the same cycle: no change.
  - gear_num updates on the clock after the debounced edge. Total latency from a stable synced input is DEBOUNCE_CYC+1 cycles, plus 2 synchronizer cycles.
  - Holding a button gives exactly one step; the button must be released (debounced) before it can step again.
- gear_n decode, registered together with gear_num:
  - gear 1 (0) = 110
  - gear 2 (1) = 101
  - gear 3 (2) = 011
  - gear 4 (3) = 111 (no switch closed)
- Steering FSM, with states IDLE, CW and CCW:
  - Synced right=1 and left=0 gives CW. Synced left=1 and right=0 gives CCW. Neither or both gives IDLE.
  - In IDLE the prescaler holds at 0 and the phase is frozen.
  - On any state change the prescaler clears to 0.
  - In CW/CCW the prescaler counts 0..STEER_DIV-1. On the wrap cycle the phase advances one Gray step and step_strb=1 for that cycle.
  - CW sequence is 00→01→11→10→00; CCW is the reverse.
  - {steer_a, steer_b} = phase.
  - The first step occurs STEER_DIV cycles after entering CW/CCW.
- Every output comes directly from a flop.

Optional Feature:
- SPRINT1_STEER_ACCEL_EN defined:
  - A 4-bit run counter counts consecutive steps. It clears on entering IDLE or on a direction change.
  - Once the run counter reaches ACCEL_STEPS, the prescaler wrap point becomes STEER_DIV/2-1 (double rate). It stays there until the run counter clears.
  - The run counter saturates and does not wrap.
- Macro undefined: fixed wrap at STEER_DIV-1; no run counter is synthesized.

Decomposition:
- Package sprint1_ctrl_pkg contains:
  - gear_t (2-bit) and the GEAR_N_LUT constant array of the four gear_n codes.
  - quad_t (2-bit) with constants Q_CW_NEXT/Q_CCW_NEXT, or next-phase functions.
  - Steering state enum steer_st_t {IDLE, CW, CCW}.
- One sub-module, sprint1_debounce (synchronizer + debounce counter, parameter DEBOUNCE_CYC), instantiated for gear_up and gear_down.
- Steering and gear logic live in the top of the block.

Test Plan:
All scenarios use DEBOUNCE_CYC=4 and STEER_DIV=4.
- Reset, then idle 20 cycles → gear_n=110, gear_num=0, steer_a/b=00, step_strb never asserted.
- gear_up held 10 cycles, released 10, repeated 4 times → gear_num goes 1,2,3,3; gear_n=111 after the third press; each change arrives 7 cycles after the input rises.
- gear_up pulse of 2 cycles → no gear change. gear_up and gear_down rising in the same cycle from gear 2 → gear stays 2.
- right held 20 cycles → phase steps 00→01→11→10→00 every 4 cycles, step_strb pulsed 5 times, first pulse 6 cycles after right rises. Switching to left mid-count → prescaler restarts and phase reverses.
- left and right both held → phase frozen, no step_strb. Reset_n asserted mid-step at gear 3 → outputs return to reset values immediately (asynchronously).
- With SPRINT1_STEER_ACCEL_EN and ACCEL_STEPS=8, right held → first 8 steps are 4 cycles apart, subsequent steps 2 cycles apart; releasing right restores the 4-cycle spacing.
